// File: rtl/ms_dual_source_pkg.sv
// Shared types for the dual-channel master-slave stimulus source.
package ms_dual_source_types;

    typedef enum logic [1:0] {
        section_idle,
        section_a,
        section_b
    } SourceSections;

    localparam int GAP_W = 8;

endpackage

// File: rtl/ms_dual_source_if.sv
// Two master-slave integer channels plus burst control between source and slave.
interface ms_dual_source_if;

    logic               en;
    logic signed [31:0] m_out;
    logic               m_out_sync;
    logic signed [31:0] m_out2;
    logic               m_out2_sync;
    logic               busy;

    modport master (
        input  en,
        output m_out,
        output m_out_sync,
        output m_out2,
        output m_out2_sync,
        output busy
    );

    modport slave (
        output en,
        input  m_out,
        input  m_out_sync,
        input  m_out2,
        input  m_out2_sync,
        input  busy
    );

endinterface

// File: rtl/ms_dual_source.sv
// Section FSM: channel-1 word, then channel-2 derived word, then a programmable idle gap.
module ms_dual_source
    import ms_dual_source_types::*;
#(
    parameter int                 GAP      = 2,
    parameter logic signed [31:0] STEP     = 32'sd1,
    parameter logic signed [31:0] OFFSET   = 32'sd100,
    parameter logic signed [31:0] VAL_INIT = 32'sd0
) (
    input  logic              clk,
    input  logic              rst,
    ms_dual_source_if.master  src
);

    localparam logic [GAP_W-1:0] GAP_L = GAP_W'(GAP);

    SourceSections      section_q, section_d;
    logic signed [31:0] val_q, val_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic signed [31:0] m_out_q, m_out_d;
    logic               m_out_sync_q, m_out_sync_d;
    logic signed [31:0] m_out2_q, m_out2_d;
    logic               m_out2_sync_q, m_out2_sync_d;
    logic               busy_q, busy_d;

    always_comb begin
        section_d     = section_q;
        val_d         = val_q;
        gap_d         = gap_q;
        m_out_d       = m_out_q;
        m_out_sync_d  = m_out_sync_q;
        m_out2_d      = m_out2_q;
        m_out2_sync_d = m_out2_sync_q;
        busy_d        = busy_q;

        case (section_q)
            section_idle: begin
                // en low freezes the gap countdown as well as the burst start
                if (src.en) begin
                    if (gap_q == '0) begin
                        section_d    = section_a;
                        m_out_d      = val_q;
                        m_out_sync_d = 1'b1;
                        busy_d       = 1'b1;
                    end else begin
                        gap_d = gap_q - 1'b1;
                    end
                end
            end
            section_a: begin
                section_d     = section_b;
                m_out_sync_d  = 1'b0;
                m_out2_d      = val_q + OFFSET;
                m_out2_sync_d = 1'b1;
            end
            section_b: begin
                section_d     = section_idle;
                m_out2_sync_d = 1'b0;
                val_d         = val_q + STEP;
                gap_d         = GAP_L;
                busy_d        = 1'b0;
            end
            default: begin
                section_d = section_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            section_q     <= section_idle;
            val_q         <= VAL_INIT;
            gap_q         <= '0;
            m_out_q       <= '0;
            m_out_sync_q  <= 1'b0;
            m_out2_q      <= '0;
            m_out2_sync_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            section_q     <= section_d;
            val_q         <= val_d;
            gap_q         <= gap_d;
            m_out_q       <= m_out_d;
            m_out_sync_q  <= m_out_sync_d;
            m_out2_q      <= m_out2_d;
            m_out2_sync_q <= m_out2_sync_d;
            busy_q        <= busy_d;
        end
    end

    assign src.m_out       = m_out_q;
    assign src.m_out_sync  = m_out_sync_q;
    assign src.m_out2      = m_out2_q;
    assign src.m_out2_sync = m_out2_sync_q;
    assign src.busy        = busy_q;

endmodule

// File: tb/tb_ms_dual_source.sv
// Directed bench for ms_dual_source: default, preloaded-wrap and zero-gap instances.
module tb_ms_dual_source;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    ms_dual_source_if bus_a ();
    ms_dual_source_if bus_w ();
    ms_dual_source_if bus_z ();

    ms_dual_source #(.GAP(2), .STEP(32'sd1), .OFFSET(32'sd100), .VAL_INIT(32'sd0))
        dut (.clk(clk), .rst(rst), .src(bus_a));
    ms_dual_source #(.GAP(2), .STEP(32'sd1), .OFFSET(32'sd1), .VAL_INIT(32'sh7FFFFFFF))
        dut_w (.clk(clk), .rst(rst), .src(bus_w));
    ms_dual_source #(.GAP(0), .STEP(32'sd1), .OFFSET(32'sd100), .VAL_INIT(32'sd0))
        dut_z (.clk(clk), .rst(rst), .src(bus_z));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        bus_a.en = 1'b1; bus_w.en = 1'b1; bus_z.en = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus_a.m_out !== 32'sd0 || bus_a.m_out2 !== 32'sd0) begin
            n_fail++; $display("FAIL reset_data got %h/%h want 0/0", bus_a.m_out, bus_a.m_out2);
        end
        n_checks++;
        if ({bus_a.m_out_sync, bus_a.m_out2_sync, bus_a.busy} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl got %b want 000", {bus_a.m_out_sync, bus_a.m_out2_sync, bus_a.busy});
        end
        n_checks++;
        if ({bus_w.m_out_sync, bus_w.m_out2_sync, bus_w.busy, bus_z.m_out_sync, bus_z.m_out2_sync, bus_z.busy} !== 6'b0) begin
            n_fail++; $display("FAIL reset_other got %b%b%b %b%b%b want all 0",
                bus_w.m_out_sync, bus_w.m_out2_sync, bus_w.busy, bus_z.m_out_sync, bus_z.m_out2_sync, bus_z.busy);
        end
        rst = 1'b0;
        bus_a.en = 1'b0; bus_w.en = 1'b0; bus_z.en = 1'b0;
        tick();
    endtask

    task automatic test_bursts;
        logic               e_s1, e_s2, e_busy;
        logic signed [31:0] e_m, e_m2;
        bus_a.en = 1'b1;
        do_reset();
        for (int c = 1; c <= 13; c++) begin
            tick();
            e_s1   = (c == 1 || c == 6 || c == 11);
            e_s2   = (c == 2 || c == 7 || c == 12);
            e_busy = e_s1 || e_s2;
            e_m    = (c - 1) / 5;
            e_m2   = (c >= 2) ? 100 + (c - 2) / 5 : 0;
            n_checks++;
            if (bus_a.m_out_sync !== e_s1) begin
                n_fail++; $display("FAIL bursts_sync1 c%0d got %b want %b", c, bus_a.m_out_sync, e_s1);
            end
            n_checks++;
            if (bus_a.m_out2_sync !== e_s2) begin
                n_fail++; $display("FAIL bursts_sync2 c%0d got %b want %b", c, bus_a.m_out2_sync, e_s2);
            end
            n_checks++;
            if (bus_a.busy !== e_busy) begin
                n_fail++; $display("FAIL bursts_busy c%0d got %b want %b", c, bus_a.busy, e_busy);
            end
            n_checks++;
            if (bus_a.m_out !== e_m) begin
                n_fail++; $display("FAIL bursts_m_out c%0d got %0d want %0d", c, bus_a.m_out, e_m);
            end
            n_checks++;
            if (bus_a.m_out2 !== e_m2) begin
                n_fail++; $display("FAIL bursts_m_out2 c%0d got %0d want %0d", c, bus_a.m_out2, e_m2);
            end
        end
        bus_a.en = 1'b0;
    endtask

    task automatic test_en_gap_freeze;
        bus_a.en = 1'b1;
        do_reset();
        repeat (4) tick();
        n_checks++;
        if (dut.gap_q !== 8'd1 || bus_a.m_out_sync !== 1'b0) begin
            n_fail++; $display("FAIL freeze_pre gap got %0d sync %b want 1 0", dut.gap_q, bus_a.m_out_sync);
        end
        bus_a.en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (dut.gap_q !== 8'd1 || bus_a.m_out_sync !== 1'b0 || bus_a.busy !== 1'b0) begin
                n_fail++; $display("FAIL freeze_hold i%0d gap %0d sync %b busy %b want 1 0 0",
                    i, dut.gap_q, bus_a.m_out_sync, bus_a.busy);
            end
        end
        bus_a.en = 1'b1;
        tick();
        n_checks++;
        if (bus_a.m_out_sync !== 1'b0) begin
            n_fail++; $display("FAIL freeze_resume1 sync got %b want 0", bus_a.m_out_sync);
        end
        tick();
        n_checks++;
        if (bus_a.m_out_sync !== 1'b1 || bus_a.m_out !== 32'sd1) begin
            n_fail++; $display("FAIL freeze_resume2 sync %b m_out %0d want 1 1", bus_a.m_out_sync, bus_a.m_out);
        end
        bus_a.en = 1'b0;
    endtask

    task automatic test_en_drop_in_burst;
        bus_a.en = 1'b1;
        do_reset();
        tick();
        n_checks++;
        if (bus_a.m_out_sync !== 1'b1) begin
            n_fail++; $display("FAIL drop_start sync1 got %b want 1", bus_a.m_out_sync);
        end
        bus_a.en = 1'b0;
        tick();
        n_checks++;
        if ({bus_a.m_out_sync, bus_a.m_out2_sync, bus_a.busy} !== 3'b011 || bus_a.m_out2 !== 32'sd100) begin
            n_fail++; $display("FAIL drop_ch2 s1/s2/busy %b%b%b m_out2 %0d want 011 100",
                bus_a.m_out_sync, bus_a.m_out2_sync, bus_a.busy, bus_a.m_out2);
        end
        tick();
        n_checks++;
        if ({bus_a.m_out2_sync, bus_a.busy} !== 2'b00) begin
            n_fail++; $display("FAIL drop_end s2/busy got %b%b want 00", bus_a.m_out2_sync, bus_a.busy);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if ({bus_a.m_out_sync, bus_a.busy} !== 2'b00) begin
                n_fail++; $display("FAIL drop_idle i%0d s1/busy got %b%b want 00", i, bus_a.m_out_sync, bus_a.busy);
            end
        end
        bus_a.en = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus_a.m_out_sync !== 1'b0) begin
            n_fail++; $display("FAIL drop_gap sync1 got %b want 0", bus_a.m_out_sync);
        end
        tick();
        n_checks++;
        if (bus_a.m_out_sync !== 1'b1 || bus_a.m_out !== 32'sd1) begin
            n_fail++; $display("FAIL drop_restart sync %b m_out %0d want 1 1", bus_a.m_out_sync, bus_a.m_out);
        end
        bus_a.en = 1'b0;
    endtask

    task automatic test_wrap;
        bus_w.en = 1'b1;
        do_reset();
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) begin
                n_checks++;
                if (bus_w.m_out_sync !== 1'b1 || bus_w.m_out !== 32'sh7FFFFFFF) begin
                    n_fail++; $display("FAIL wrap_c1 sync %b m_out %h want 1 7fffffff", bus_w.m_out_sync, bus_w.m_out);
                end
            end
            if (c == 2) begin
                n_checks++;
                if (bus_w.m_out2_sync !== 1'b1 || bus_w.m_out2 !== 32'sh80000000) begin
                    n_fail++; $display("FAIL wrap_c2 sync2 %b m_out2 %h want 1 80000000", bus_w.m_out2_sync, bus_w.m_out2);
                end
            end
            if (c == 6) begin
                n_checks++;
                if (bus_w.m_out_sync !== 1'b1 || bus_w.m_out !== 32'sh80000000) begin
                    n_fail++; $display("FAIL wrap_c6 sync %b m_out %h want 1 80000000", bus_w.m_out_sync, bus_w.m_out);
                end
            end
            if (c == 7) begin
                n_checks++;
                if (bus_w.m_out2_sync !== 1'b1 || bus_w.m_out2 !== 32'sh80000001) begin
                    n_fail++; $display("FAIL wrap_c7 sync2 %b m_out2 %h want 1 80000001", bus_w.m_out2_sync, bus_w.m_out2);
                end
            end
        end
        bus_w.en = 1'b0;
    endtask

    task automatic test_reset_mid_burst;
        bus_a.en = 1'b1;
        do_reset();
        repeat (6) tick();
        n_checks++;
        if (bus_a.m_out_sync !== 1'b1 || bus_a.m_out !== 32'sd1) begin
            n_fail++; $display("FAIL midrst_pre sync %b m_out %0d want 1 1", bus_a.m_out_sync, bus_a.m_out);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if ({bus_a.m_out_sync, bus_a.m_out2_sync, bus_a.busy} !== 3'b000 ||
            bus_a.m_out !== 32'sd0 || bus_a.m_out2 !== 32'sd0) begin
            n_fail++; $display("FAIL midrst_clear s1/s2/busy %b%b%b data %0d/%0d want 000 0/0",
                bus_a.m_out_sync, bus_a.m_out2_sync, bus_a.busy, bus_a.m_out, bus_a.m_out2);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (bus_a.m_out_sync !== 1'b1 || bus_a.m_out !== 32'sd0 || bus_a.busy !== 1'b1) begin
            n_fail++; $display("FAIL midrst_restart sync %b m_out %0d busy %b want 1 0 1",
                bus_a.m_out_sync, bus_a.m_out, bus_a.busy);
        end
        tick();
        n_checks++;
        if (bus_a.m_out2_sync !== 1'b1 || bus_a.m_out2 !== 32'sd100) begin
            n_fail++; $display("FAIL midrst_ch2 sync2 %b m_out2 %0d want 1 100", bus_a.m_out2_sync, bus_a.m_out2);
        end
        bus_a.en = 1'b0;
    endtask

    task automatic test_gap0;
        logic e_s1, e_s2, e_busy;
        bus_z.en = 1'b1;
        do_reset();
        for (int c = 1; c <= 12; c++) begin
            tick();
            e_s1   = (c % 3 == 1);
            e_s2   = (c % 3 == 2);
            e_busy = (c % 3 != 0);
            n_checks++;
            if ({bus_z.m_out_sync, bus_z.m_out2_sync, bus_z.busy} !== {e_s1, e_s2, e_busy}) begin
                n_fail++; $display("FAIL gap0_ctrl c%0d s1/s2/busy got %b%b%b want %b%b%b",
                    c, bus_z.m_out_sync, bus_z.m_out2_sync, bus_z.busy, e_s1, e_s2, e_busy);
            end
            n_checks++;
            if ((bus_z.m_out_sync & bus_z.m_out2_sync) !== 1'b0) begin
                n_fail++; $display("FAIL gap0_overlap c%0d both strobes high", c);
            end
            if (e_s1) begin
                n_checks++;
                if (bus_z.m_out !== 32'((c - 1) / 3)) begin
                    n_fail++; $display("FAIL gap0_m_out c%0d got %0d want %0d", c, bus_z.m_out, (c - 1) / 3);
                end
            end
        end
        bus_z.en = 1'b0;
    endtask

    initial begin
        bus_a.en = 1'b0;
        bus_w.en = 1'b0;
        bus_z.en = 1'b0;
        test_reset();
        test_bursts();
        test_en_gap_freeze();
        test_en_drop_in_burst();
        test_wrap();
        test_reset_mid_burst();
        test_gap0();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
